// File: rtl/reset_seq_ctrl_if.sv
// Reset sequencer bus: software restart request, per-domain acks in,
// per-domain resets and status flags out. The slave modport is the sequencer.
interface reset_seq_ctrl_if #(
  parameter int NUM_DOM = 4
);
  logic               sw_req_i;
  logic [NUM_DOM-1:0] ack_i;
  logic [NUM_DOM-1:0] rst_o;
  logic               ready_o;
  logic               err_o;

  modport master (
    output sw_req_i, ack_i,
    input  rst_o, ready_o, err_o
  );

  modport slave (
    input  sw_req_i, ack_i,
    output rst_o, ready_o, err_o
  );
endinterface

// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: holds NUM_DOM reset domains in reset for MIN_WIDTH edges
// after the master reset drops, then releases them one by one from bit 0
// upward, GAP edges apart. A pulse on sw_req_i while running restarts the
// sequence. Optional feature macro: RST_SEQ_ACK_EN -- each release also waits
// for the previous domain's ack, with an ACK_TIMEOUT watchdog driving err_o.
// All outputs come straight from registers.
module reset_seq_ctrl #(
  parameter int NUM_DOM     = 4,
  parameter int MIN_WIDTH   = 4,
  parameter int GAP         = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_i,
  reset_seq_ctrl_if.slave bus
);

  // Counter only needs to reach the largest threshold; it saturates there.
  localparam int MAX_AB  = (MIN_WIDTH > GAP) ? MIN_WIDTH : GAP;
  localparam int CNT_MAX = (MAX_AB > ACK_TIMEOUT) ? MAX_AB : ACK_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(NUM_DOM);

  typedef enum logic [1:0] {ASSERT, HOLD, RELEASE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;     // edges already counted in this phase
  logic [IW-1:0]      idx_q, idx_d;     // most recently released domain
  logic [NUM_DOM-1:0] rst_q, rst_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic [CW-1:0]      cnt_inc;
  logic               gap_met;

`ifdef RST_SEQ_ACK_EN
  logic ack_seen_q, ack_seen_d;
  logic ack_now;
  logic timeout;
`else
  logic unused_ack;
  assign unused_ack = ^bus.ack_i;
`endif

  assign cnt_inc = (cnt_q == CW'(CNT_MAX)) ? cnt_q : cnt_q + CW'(1);
  // The edge being evaluated is edge cnt_q+1 of the current phase.
  assign gap_met = (int'(cnt_q) + 1 >= GAP);

  // Next-state and output logic; defaults hold every register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    err_d   = err_q;
`ifdef RST_SEQ_ACK_EN
    ack_seen_d = ack_seen_q;
    ack_now    = bus.ack_i[idx_q];
    timeout    = 1'b0;
`endif
    case (state_q)
      // ASSERT with rst_i low is edge 1 of the hold phase (cnt_q is 0 there).
      ASSERT, HOLD: begin
        if (int'(cnt_q) + 1 >= MIN_WIDTH) begin
          state_d = RELEASE;
          rst_d   = rst_q << 1;
          idx_d   = '0;
          cnt_d   = '0;
`ifdef RST_SEQ_ACK_EN
          ack_seen_d = 1'b0;
`endif
        end else begin
          state_d = HOLD;
          cnt_d   = cnt_inc;
        end
      end
      RELEASE: begin
`ifdef RST_SEQ_ACK_EN
        // Ack is registered first, so the release lands one edge after it.
        timeout    = !ack_seen_q && !ack_now && (int'(cnt_q) + 1 >= ACK_TIMEOUT);
        ack_seen_d = ack_seen_q | ack_now | timeout;
        if (timeout) err_d = 1'b1;
        if (gap_met && ack_seen_q) begin
          cnt_d      = '0;
          ack_seen_d = 1'b0;
          if (idx_q == IW'(NUM_DOM - 1)) begin
            state_d = RUN;
            ready_d = 1'b1;
          end else begin
            rst_d = rst_q << 1;
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_inc;
        end
`else
        if (gap_met) begin
          rst_d = rst_q << 1;
          cnt_d = '0;
          if (idx_q == IW'(NUM_DOM - 2)) begin
            state_d = RUN;
            ready_d = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      RUN: begin
        // Software restart skips ASSERT; the next edge counts as hold edge 1.
        if (bus.sw_req_i) begin
          state_d = HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          rst_d   = '1;
          ready_d = 1'b0;
          err_d   = 1'b0;
`ifdef RST_SEQ_ACK_EN
          ack_seen_d = 1'b0;
`endif
        end
      end
      default: state_d = ASSERT;
    endcase
  end

  // State and output registers; master reset overrides everything, sw_req_i included.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef RST_SEQ_ACK_EN
      ack_seen_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      err_q   <= err_d;
`ifdef RST_SEQ_ACK_EN
      ack_seen_q <= ack_seen_d;
`endif
    end
  end

  assign bus.rst_o   = rst_q;
  assign bus.ready_o = ready_q;
  assign bus.err_o   = err_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl with default parameters (no ack feature).
module tb_reset_seq_ctrl;

  logic clk = 1'b0;
  logic rst_i;
  int   tests = 0;
  int   fails = 0;
  logic [3:0] tbl_rst [1:10];

  always #5 clk = ~clk;

  reset_seq_ctrl_if #(.NUM_DOM(4)) bus ();

  reset_seq_ctrl #(
    .NUM_DOM(4), .MIN_WIDTH(4), .GAP(2), .ACK_TIMEOUT(16)
  ) dut (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk edges n=1..upto of a release sequence, optionally pulsing sw_req_i at edge sw_at.
  task automatic run_seq(input string tag, input int upto, input int sw_at);
    for (int n = 1; n <= upto; n++) begin
      if (n == sw_at) bus.sw_req_i = 1'b1;
      tick();
      bus.sw_req_i = 1'b0;
      check($sformatf("%s n=%0d rst_o", tag, n), 32'(bus.rst_o), 32'(tbl_rst[n]));
      check($sformatf("%s n=%0d ready_o", tag, n), 32'(bus.ready_o), (n == 10) ? 32'd1 : 32'd0);
    end
    check($sformatf("%s err_o", tag), 32'(bus.err_o), 32'd0);
  endtask

  initial begin
    tbl_rst = '{4'b1111, 4'b1111, 4'b1111, 4'b1110, 4'b1110,
                4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b0000};
    rst_i        = 1'b1;
    bus.sw_req_i = 1'b0;
    bus.ack_i    = '0;

    // Power-on reset held 3 cycles
    repeat (3) tick();
    check("reset rst_o", 32'(bus.rst_o), 32'hF);
    check("reset ready_o", 32'(bus.ready_o), 32'd0);
    check("reset err_o", 32'(bus.err_o), 32'd0);

    // Full release sequence
    rst_i = 1'b0;
    run_seq("por", 10, 0);
    repeat (3) tick();
    check("run hold rst_o", 32'(bus.rst_o), 32'h0);
    check("run hold ready_o", 32'(bus.ready_o), 32'd1);

    // Software restart from RUN; a second pulse mid-sequence must be ignored
    bus.sw_req_i = 1'b1;
    tick();
    bus.sw_req_i = 1'b0;
    check("sw edge rst_o", 32'(bus.rst_o), 32'hF);
    check("sw edge ready_o", 32'(bus.ready_o), 32'd0);
    run_seq("sw", 10, 5);

    // Master reset re-asserted at edge 7 of a sequence
    rst_i = 1'b1;
    tick();
    check("rerst rst_o", 32'(bus.rst_o), 32'hF);
    rst_i = 1'b0;
    run_seq("pre", 6, 0);
    rst_i = 1'b1;
    tick();
    check("mid rst rst_o", 32'(bus.rst_o), 32'hF);
    check("mid rst ready_o", 32'(bus.ready_o), 32'd0);
    rst_i = 1'b0;
    run_seq("mid", 10, 0);

    // rst_i and sw_req_i together in RUN: reset wins
    rst_i        = 1'b1;
    bus.sw_req_i = 1'b1;
    tick();
    check("both rst_o", 32'(bus.rst_o), 32'hF);
    check("both ready_o", 32'(bus.ready_o), 32'd0);
    bus.sw_req_i = 1'b0;
    tick();
    check("both held rst_o", 32'(bus.rst_o), 32'hF);
    rst_i = 1'b0;
    run_seq("both", 10, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
